// File: rtl/sync_fifo_pkg.sv
// Shared types and helpers for sync_fifo: wrapping pointer increment and a status bundle.
// Latency: n/a (combinational helpers only).
// Backpressure: n/a.
package sync_fifo_pkg;

    localparam int unsigned STATUS_USAGE_W = 16;

    typedef struct packed {
        logic                      full;
        logic                      empty;
        logic [STATUS_USAGE_W-1:0] usage;
    } fifo_status_t;

    // Explicit wrap so non-power-of-2 depths never visit unused slots.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// fifo_ptr: wrapping pointer counter over 0..DEPTH-1 with synchronous clear.
// Latency: ptr_o updates on the edge after inc_i/clr_i.
// Backpressure: none; clr_i overrides inc_i.
module fifo_ptr
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = PTR_W'(next_ptr(32'(ptr_q), DEPTH));
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO, any DEPTH >= 2; SYNC_FIFO_ERR_FLAGS_EN adds sticky overflow_o/underflow_o.
// Latency: a push into an empty FIFO shows on rdata_o the next cycle; flags decode the registered count.
// Backpressure: push while full is dropped unless a pop is accepted the same cycle; pop while empty is ignored.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] usage_o
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic             overflow_o,
    output logic             underflow_o
`endif
);

    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             full;
    logic             empty;
    logic             push_acc;
    logic             pop_acc;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // A pop frees the slot the same cycle, so a full FIFO still takes a push alongside it.
    always_comb begin
        pop_acc  = pop_i && !empty;
        push_acc = push_i && (!full || pop_acc);
        count_d  = count_q;
        if (flush_i) begin
            count_d = '0;
        end else if (push_acc && !pop_acc) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    fifo_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .clr_i   (flush_i),
        .inc_i   (push_acc),
        .ptr_o   (wptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .clr_i   (flush_i),
        .inc_i   (pop_acc),
        .ptr_o   (rptr)
    );

    // Storage is deliberately left unreset; contents are meaningless while empty.
    always_ff @(posedge clk_i) begin
        if (push_acc && !flush_i) begin
            mem_q[wptr] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr];
    assign full_o  = full;
    assign empty_o = empty;
    assign usage_o = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic overflow_d;
    logic underflow_q;
    logic underflow_d;

    always_comb begin
        overflow_d  = overflow_q  | (push_i && !push_acc);
        underflow_d = underflow_q | (pop_i && !pop_acc);
        if (flush_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: a DEPTH=4 and a DEPTH=3 instance checked against queue-based reference models.
module tb_sync_fifo;

    logic       clk;
    logic       arst_n;

    logic       flush4, push4, pop4;
    logic [7:0] wdata4, rdata4;
    logic       full4, empty4;
    logic [2:0] usage4;

    logic       flush3, push3, pop3;
    logic [7:0] wdata3, rdata3;
    logic       full3, empty3;
    logic [1:0] usage3;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       ovf4, udf4, ovf3, udf3;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] q4[$];
    logic [7:0] q3[$];
    bit         m_ovf4, m_udf4, m_ovf3, m_udf3;

    sync_fifo #(.DEPTH(4), .WIDTH(8)) u_dut4 (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .flush_i     (flush4),
        .push_i      (push4),
        .wdata_i     (wdata4),
        .pop_i       (pop4),
        .rdata_o     (rdata4),
        .full_o      (full4),
        .empty_o     (empty4),
        .usage_o     (usage4)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow_o  (ovf4),
        .underflow_o (udf4)
`endif
    );

    sync_fifo #(.DEPTH(3), .WIDTH(8)) u_dut3 (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .flush_i     (flush3),
        .push_i      (push3),
        .wdata_i     (wdata3),
        .pop_i       (pop3),
        .rdata_o     (rdata3),
        .full_o      (full3),
        .empty_o     (empty3),
        .usage_o     (usage3)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .overflow_o  (ovf3),
        .underflow_o (udf3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock on the DEPTH=4 instance; the model applies the FIFO rules to a queue.
    task automatic cyc4(input bit fl, input bit pu, input bit po, input logic [7:0] d);
        bit pop_ok, push_ok;
        int n;
        flush4 = fl; push4 = pu; pop4 = po; wdata4 = d;
        @(posedge clk);
        n = q4.size();
        if (fl) begin
            q4.delete(); m_ovf4 = 0; m_udf4 = 0;
        end else begin
            pop_ok  = po && (n > 0);
            push_ok = pu && ((n < 4) || pop_ok);
            if (pop_ok) void'(q4.pop_front());
            if (push_ok) q4.push_back(d);
            if (pu && !push_ok) m_ovf4 = 1;
            if (po && n == 0) m_udf4 = 1;
        end
        #1;
        flush4 = 0; push4 = 0; pop4 = 0;
    endtask

    task automatic cyc3(input bit fl, input bit pu, input bit po, input logic [7:0] d);
        bit pop_ok, push_ok;
        int n;
        flush3 = fl; push3 = pu; pop3 = po; wdata3 = d;
        @(posedge clk);
        n = q3.size();
        if (fl) begin
            q3.delete(); m_ovf3 = 0; m_udf3 = 0;
        end else begin
            pop_ok  = po && (n > 0);
            push_ok = pu && ((n < 3) || pop_ok);
            if (pop_ok) void'(q3.pop_front());
            if (push_ok) q3.push_back(d);
            if (pu && !push_ok) m_ovf3 = 1;
            if (po && n == 0) m_udf3 = 1;
        end
        #1;
        flush3 = 0; push3 = 0; pop3 = 0;
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        #12;
        checks++;
        if (usage4 !== 3'd0 || empty4 !== 1'b1 || full4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_in: usage=%0d empty=%b full=%b expected 0/1/0", usage4, empty4, full4);
        end
        @(negedge clk);
        arst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc4(0, 0, 0, 8'h00);
            checks++;
            if (usage4 !== 3'd0 || empty4 !== 1'b1 || full4 !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: usage=%0d empty=%b full=%b expected 0/1/0", i, usage4, empty4, full4);
            end
            checks++;
            if (usage3 !== 2'd0 || empty3 !== 1'b1 || full3 !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle3[%0d]: usage=%0d empty=%b full=%b expected 0/1/0", i, usage3, empty3, full3);
            end
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (ovf4 !== 1'b0 || udf4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: ovf=%b udf=%b expected 0/0", ovf4, udf4);
        end
`endif
    endtask

    task automatic test_fill_drain;
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) cyc4(0, 1, 0, 8'(8'hA1 + i));
        checks++;
        if (full4 !== 1'b1 || usage4 !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: full=%b usage=%0d expected 1/4", full4, usage4);
        end
        cyc4(0, 1, 0, 8'hFF);
        checks++;
        if (full4 !== 1'b1 || usage4 !== 3'd4 || rdata4 !== 8'hA1) begin
            errors++;
            $display("FAIL fill_drop: full=%b usage=%0d head=%h expected 1/4/a1", full4, usage4, rdata4);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (ovf4 !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow: got %b expected 1", ovf4);
        end
`endif
        for (int i = 0; i < 4; i++) begin
            exp = 8'(8'hA1 + i);
            checks++;
            if (rdata4 !== exp) begin
                errors++;
                $display("FAIL drain_data[%0d]: got %h expected %h", i, rdata4, exp);
            end
            cyc4(0, 0, 1, 8'h00);
        end
        checks++;
        if (empty4 !== 1'b1 || usage4 !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: empty=%b usage=%0d expected 1/0", empty4, usage4);
        end
    endtask

    task automatic test_wrap_depth3;
        logic [7:0] exp_next;
        exp_next = 8'd0;
        cyc3(0, 1, 0, 8'd0);
        cyc3(0, 1, 0, 8'd1);
        for (int i = 2; i < 10; i++) begin
            checks++;
            if (rdata3 !== exp_next) begin
                errors++;
                $display("FAIL wrap_data[%0d]: got %0d expected %0d", i, rdata3, exp_next);
            end
            cyc3(0, 1, 1, 8'(i));
            exp_next++;
            checks++;
            if (usage3 !== 2'd2 || full3 !== 1'b0) begin
                errors++;
                $display("FAIL wrap_usage[%0d]: usage=%0d full=%b expected 2/0", i, usage3, full3);
            end
        end
        while (exp_next < 8'd10) begin
            checks++;
            if (rdata3 !== exp_next) begin
                errors++;
                $display("FAIL wrap_drain: got %0d expected %0d", rdata3, exp_next);
            end
            cyc3(0, 0, 1, 8'd0);
            exp_next++;
        end
        checks++;
        if (empty3 !== 1'b1 || usage3 !== 2'd0) begin
            errors++;
            $display("FAIL wrap_empty: empty=%b usage=%0d expected 1/0", empty3, usage3);
        end
    endtask

    task automatic test_full_push_pop;
        logic [7:0] arr [4];
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) begin
            arr[i] = 8'($urandom_range(0, 255));
            cyc4(0, 1, 0, arr[i]);
        end
        cyc4(0, 1, 1, 8'h55);
        checks++;
        if (usage4 !== 3'd4 || full4 !== 1'b1 || rdata4 !== arr[1]) begin
            errors++;
            $display("FAIL full_pp: usage=%0d full=%b head=%h expected 4/1/%h", usage4, full4, rdata4, arr[1]);
        end
        for (int i = 1; i < 5; i++) begin
            exp = (i == 4) ? 8'h55 : arr[i];
            checks++;
            if (rdata4 !== exp) begin
                errors++;
                $display("FAIL full_pp_order[%0d]: got %h expected %h", i, rdata4, exp);
            end
            cyc4(0, 0, 1, 8'h00);
        end
        checks++;
        if (empty4 !== 1'b1) begin
            errors++;
            $display("FAIL full_pp_empty: got %b expected 1", empty4);
        end
    endtask

    task automatic test_empty_push_pop;
        cyc4(0, 1, 1, 8'h33);
        checks++;
        if (usage4 !== 3'd1 || empty4 !== 1'b0 || rdata4 !== 8'h33) begin
            errors++;
            $display("FAIL empty_pp: usage=%0d empty=%b head=%h expected 1/0/33", usage4, empty4, rdata4);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (udf4 !== 1'b1) begin
            errors++;
            $display("FAIL empty_pp_underflow: got %b expected 1", udf4);
        end
`endif
    endtask

    task automatic test_flush_and_arst;
        cyc4(0, 1, 0, 8'h44);
        checks++;
        if (usage4 !== 3'd2) begin
            errors++;
            $display("FAIL flush_pre: usage=%0d expected 2", usage4);
        end
        cyc4(1, 1, 0, 8'h77);
        checks++;
        if (usage4 !== 3'd0 || empty4 !== 1'b1 || full4 !== 1'b0) begin
            errors++;
            $display("FAIL flush: usage=%0d empty=%b full=%b expected 0/1/0", usage4, empty4, full4);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        checks++;
        if (ovf4 !== 1'b0 || udf4 !== 1'b0) begin
            errors++;
            $display("FAIL flush_flags: ovf=%b udf=%b expected 0/0", ovf4, udf4);
        end
`endif
        cyc4(0, 0, 0, 8'h00);
        checks++;
        if (empty4 !== 1'b1) begin
            errors++;
            $display("FAIL flush_discard: empty=%b expected 1", empty4);
        end
        cyc4(0, 1, 0, 8'h10);
        cyc4(0, 1, 0, 8'h20);
        cyc3(0, 1, 0, 8'h30);
        cyc4(0, 1, 1, 8'h00);
        push4 = 1'b1; wdata4 = 8'h99;
        @(posedge clk);
        #2;
        arst_n = 1'b0;
        #1;
        checks++;
        if (usage4 !== 3'd0 || empty4 !== 1'b1 || full4 !== 1'b0) begin
            errors++;
            $display("FAIL arst4: usage=%0d empty=%b full=%b expected 0/1/0", usage4, empty4, full4);
        end
        checks++;
        if (usage3 !== 2'd0 || empty3 !== 1'b1) begin
            errors++;
            $display("FAIL arst3: usage=%0d empty=%b expected 0/1", usage3, empty3);
        end
        q4.delete(); q3.delete();
        m_ovf4 = 0; m_udf4 = 0; m_ovf3 = 0; m_udf3 = 0;
        push4 = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_random;
        bit fl, pu, po;
        int bias;
        for (int n = 0; n < 400; n++) begin
            bias = ((n / 40) % 2 == 0) ? 75 : 30;
            fl = ($urandom_range(0, 59) == 0);
            pu = ($urandom_range(0, 99) < bias);
            po = ($urandom_range(0, 99) < (100 - bias));
            cyc4(fl, pu, po, 8'($urandom_range(0, 255)));
            checks++;
            if (usage4 !== 3'(q4.size()) || empty4 !== (q4.size() == 0) || full4 !== (q4.size() == 4)) begin
                errors++;
                $display("FAIL rand4_state[%0d]: usage=%0d empty=%b full=%b expected usage %0d", n, usage4, empty4, full4, q4.size());
            end
            if (q4.size() > 0) begin
                checks++;
                if (rdata4 !== q4[0]) begin
                    errors++;
                    $display("FAIL rand4_data[%0d]: got %h expected %h", n, rdata4, q4[0]);
                end
            end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            checks++;
            if (ovf4 !== m_ovf4 || udf4 !== m_udf4) begin
                errors++;
                $display("FAIL rand4_flags[%0d]: ovf=%b udf=%b expected %b/%b", n, ovf4, udf4, m_ovf4, m_udf4);
            end
`endif
        end
        for (int n = 0; n < 300; n++) begin
            bias = ((n / 30) % 2 == 0) ? 70 : 35;
            fl = ($urandom_range(0, 59) == 0);
            pu = ($urandom_range(0, 99) < bias);
            po = ($urandom_range(0, 99) < (100 - bias));
            cyc3(fl, pu, po, 8'($urandom_range(0, 255)));
            checks++;
            if (usage3 !== 2'(q3.size()) || empty3 !== (q3.size() == 0) || full3 !== (q3.size() == 3)) begin
                errors++;
                $display("FAIL rand3_state[%0d]: usage=%0d empty=%b full=%b expected usage %0d", n, usage3, empty3, full3, q3.size());
            end
            if (q3.size() > 0) begin
                checks++;
                if (rdata3 !== q3[0]) begin
                    errors++;
                    $display("FAIL rand3_data[%0d]: got %h expected %h", n, rdata3, q3[0]);
                end
            end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            checks++;
            if (ovf3 !== m_ovf3 || udf3 !== m_udf3) begin
                errors++;
                $display("FAIL rand3_flags[%0d]: ovf=%b udf=%b expected %b/%b", n, ovf3, udf3, m_ovf3, m_udf3);
            end
`endif
        end
    endtask

    initial begin
        flush4 = 0; push4 = 0; pop4 = 0; wdata4 = 8'h00;
        flush3 = 0; push3 = 0; pop3 = 0; wdata3 = 8'h00;
        m_ovf4 = 0; m_udf4 = 0; m_ovf3 = 0; m_udf3 = 0;
        test_reset();
        test_fill_drain();
        test_wrap_depth3();
        test_full_push_pop();
        test_empty_push_pop();
        test_flush_and_arst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
